// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared field widths, beat layout, loader states and instruction struct
package seq_pkg;

  localparam int FLG_W  = 64;
  localparam int OP_W   = 4;
  localparam int DATA_W = 20;
  localparam int TIME_W = 32;
  localparam int WORD_W = FLG_W + OP_W + DATA_W + TIME_W;

  localparam int BEAT_W = 32;

  // Host beat placement inside the 120-bit word; the last beat only carries 24 bits
  localparam int BEAT0_HI = 119;
  localparam int BEAT0_LO = 88;
  localparam int BEAT1_HI = 87;
  localparam int BEAT1_LO = 56;
  localparam int BEAT2_HI = 55;
  localparam int BEAT2_LO = 24;
  localparam int BEAT3_HI = 23;
  localparam int BEAT3_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } load_state_t;

  typedef struct packed {
    logic [FLG_W-1:0]  flg;
    logic [OP_W-1:0]   op_code;
    logic [DATA_W-1:0] data;
    logic [TIME_W-1:0] time_arg;
  } seq_instr_t;

endpackage

// File: rtl/seq_beat_packer.sv
// rtl/seq_beat_packer.sv - assembles four 32-bit host beats into one instruction word
module seq_beat_packer
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              clear,
  input  logic [BEAT_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0] beat_cnt;

  // Final beat is being taken this cycle; the full word is visible from the next cycle
  assign word_valid = accept & ~clear & (beat_cnt == 2'd3);

  // Beat counter and assembly register; clear discards any partial word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= 2'd0;
      word     <= '0;
    end else if (clear) begin
      beat_cnt <= 2'd0;
    end else if (accept) begin
      case (beat_cnt)
        2'd0:    word[BEAT0_HI:BEAT0_LO] <= data;
        2'd1:    word[BEAT1_HI:BEAT1_LO] <= data;
        2'd2:    word[BEAT2_HI:BEAT2_LO] <= data;
        default: word[BEAT3_HI:BEAT3_LO] <= data[BEAT3_HI-BEAT3_LO:0];
      endcase
      beat_cnt <= beat_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/seq_loader.sv
// rtl/seq_loader.sv - host loader into instruction RAM with decoder-priority port sharing
module seq_loader #(
  parameter int ADDR_SIZE = 16,
  parameter int WORD_W    = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [ADDR_SIZE-1:0] load_base,
  input  logic [ADDR_SIZE-1:0] load_count,
  input  logic                 abort,
  input  logic                 wr_valid,
  input  logic [31:0]          wr_data,
  output logic                 wr_ready,
  input  logic                 dec_run,
  input  logic [ADDR_SIZE-1:0] dec_addr,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_we,
  output logic [WORD_W-1:0]    ram_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  import seq_pkg::*;

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

  load_state_t          state;
  logic [ADDR_SIZE-1:0] count_q;
  logic [ADDR_SIZE-1:0] word_idx;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE:0]   end_addr;
  logic                 range_bad;
  logic                 last_word;
  logic                 beat_accept;
  logic                 pack_clear;
  logic                 word_done;

  // One past the last address, kept one bit wider so a load ending exactly at the top is legal
  assign end_addr  = {1'b0, load_base} + {1'b0, load_count};
  assign range_bad = end_addr[ADDR_SIZE] & (|end_addr[ADDR_SIZE-1:0]);

  assign last_word   = (word_idx + ADDR_ONE) == count_q;
  assign wr_ready    = (state == ST_COLLECT);
  assign beat_accept = wr_valid & wr_ready;
  // Holding the packer cleared while idle starts every load at beat 0
  assign pack_clear  = abort | (state == ST_IDLE);

  // The decoder sees the RAM in every cycle except the single write cycle
  assign ram_addr = ram_we ? wr_addr : dec_addr;

  seq_beat_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (beat_accept),
    .clear      (pack_clear),
    .data       (wr_data),
    .word       (ram_wdata),
    .word_valid (word_done)
  );

  // Load FSM: start/abort handling, write scheduling around dec_run, address counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ram_we   <= 1'b0;
      count_q  <= '0;
      word_idx <= '0;
      wr_addr  <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      ram_we <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (load_start) begin
              if (load_count == '0) begin
                done <= 1'b1;
              end else if (range_bad) begin
                err <= 1'b1;
              end else begin
                count_q  <= load_count;
                wr_addr  <= load_base;
                word_idx <= '0;
                busy     <= 1'b1;
                state    <= ST_COLLECT;
              end
            end
          end
          ST_COLLECT: begin
            err <= load_start;
            if (word_done) begin
              state <= ST_WRITE;
              // With the RAM free, the write is issued for the very next cycle
              if (!dec_run) begin
                ram_we <= 1'b1;
                done   <= last_word;
              end
            end
          end
          ST_WRITE: begin
            err <= load_start;
            if (ram_we) begin
              word_idx <= word_idx + ADDR_ONE;
              wr_addr  <= wr_addr + ADDR_ONE;
              if (last_word) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ST_COLLECT;
              end
            end else if (!dec_run) begin
              ram_we <= 1'b1;
              done   <= last_word;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_loader.sv
// tb/tb_seq_loader.sv - directed self-checking bench for seq_loader
module tb_seq_loader;
  import seq_pkg::*;

  logic         clk_tb = 1'b0;
  logic         reset = 1'b0;
  logic         load_start = 1'b0;
  logic [15:0]  load_base = '0;
  logic [15:0]  load_count = '0;
  logic         abort = 1'b0;
  logic         wr_valid = 1'b0;
  logic [31:0]  wr_data = '0;
  logic         wr_ready;
  logic         dec_run = 1'b0;
  logic [15:0]  dec_addr = '0;
  logic [15:0]  ram_addr;
  logic         ram_we;
  logic [119:0] ram_wdata;
  logic         busy;
  logic         done;
  logic         err;

  int tests_run = 0;
  int tests_failed = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [119:0] mem [logic [15:0]];

  // Hand-built instruction words {flg, op_code, data, time_arg}
  localparam logic [119:0] W1 = {64'd1, 4'd2, 20'd20, 32'd0};
  localparam logic [119:0] W2 = {64'd0, 4'd3, 20'd2, 32'd0};
  localparam logic [119:0] W3 = {64'hDEADBEEF_0BADF00D, 4'hF, 20'hABCDE, 32'h12345678};

  seq_loader #(.ADDR_SIZE(16), .WORD_W(120)) dut (
    .clk        (clk_tb),
    .reset      (reset),
    .load_start (load_start),
    .load_base  (load_base),
    .load_count (load_count),
    .abort      (abort),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .dec_run    (dec_run),
    .dec_addr   (dec_addr),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk_tb = ~clk_tb;

  // RAM model and pulse counters
  always @(posedge clk_tb) begin
    if (ram_we) begin
      we_cnt++;
      mem[ram_addr] = ram_wdata;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_tb);
    #1;
  endtask

  function automatic logic [31:0] beat_of(input logic [119:0] w, input int k);
    case (k)
      0:       return w[119:88];
      1:       return w[87:56];
      2:       return w[55:24];
      default: return {8'hA5, w[23:0]};
    endcase
  endfunction

  task automatic send_beat(input logic [31:0] d);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    wr_valid = 1'b1;
    wr_data = d;
    while (!acc && n < 200) begin
      acc = wr_ready;
      step();
      n++;
    end
    wr_valid = 1'b0;
    if (!acc) check("beat_accept_timeout", 128'(acc), 128'(1));
  endtask

  task automatic send_word(input logic [119:0] w);
    for (int k = 0; k < 4; k++) send_beat(beat_of(w, k));
  endtask

  task automatic start_load(input logic [15:0] base, input logic [15:0] cnt);
    load_base = base;
    load_count = cnt;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  initial begin
    int w0;
    int d0;
    int e0;
    int stall_bad;

    // Reset state
    dec_addr = 16'h1234;
    repeat (3) step();
    check("rst_wr_ready", 128'(wr_ready), 128'(0));
    check("rst_ram_we", 128'(ram_we), 128'(0));
    check("rst_ram_wdata", 128'(ram_wdata), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_ram_addr", 128'(ram_addr), 128'(16'h1234));
    reset = 1'b1;
    step();

    // Two-word load, RAM free
    w0 = we_cnt; d0 = done_cnt;
    start_load(16'h0010, 16'd2);
    check("t1_start_ready", 128'(wr_ready), 128'(1));
    check("t1_start_busy", 128'(busy), 128'(1));
    send_word(W1);
    check("t1_w0_we", 128'(ram_we), 128'(1));
    check("t1_w0_addr", 128'(ram_addr), 128'(16'h0010));
    check("t1_w0_data", 128'(ram_wdata), 128'(W1));
    check("t1_w0_done", 128'(done), 128'(0));
    check("t1_w0_ready", 128'(wr_ready), 128'(0));
    step();
    check("t1_ready_again", 128'(wr_ready), 128'(1));
    check("t1_we_single", 128'(ram_we), 128'(0));
    send_word(W2);
    check("t1_w1_we", 128'(ram_we), 128'(1));
    check("t1_w1_addr", 128'(ram_addr), 128'(16'h0011));
    check("t1_done", 128'(done), 128'(1));
    check("t1_busy_at_done", 128'(busy), 128'(1));
    step();
    check("t1_busy_after", 128'(busy), 128'(0));
    check("t1_done_pulse", 128'(done), 128'(0));
    check("t1_mem10", 128'(mem[16'h0010]), 128'(W1));
    check("t1_mem11", 128'(mem[16'h0011]), 128'(W2));
    check("t1_we_count", 128'(we_cnt - w0), 128'(2));
    check("t1_done_count", 128'(done_cnt - d0), 128'(1));

    // Decoder takes the RAM from beat 2 for 30 cycles
    w0 = we_cnt;
    start_load(16'h0040, 16'd2);
    send_beat(beat_of(W1, 0));
    send_beat(beat_of(W1, 1));
    dec_run = 1'b1;
    send_beat(beat_of(W1, 2));
    send_beat(beat_of(W1, 3));
    check("t2_stall_we", 128'(ram_we), 128'(0));
    check("t2_stall_ready", 128'(wr_ready), 128'(0));
    stall_bad = 0;
    for (int i = 0; i < 28; i++) begin
      dec_addr = 16'h0100 + 16'(i);
      #1;
      if (ram_we !== 1'b0 || ram_addr !== dec_addr) stall_bad++;
      step();
    end
    check("t2_stall_tracking", 128'(stall_bad), 128'(0));
    check("t2_stall_nowrite", 128'(we_cnt - w0), 128'(0));
    dec_run = 1'b0;
    dec_addr = 16'h0200;
    step();
    check("t2_late_we", 128'(ram_we), 128'(1));
    check("t2_late_addr", 128'(ram_addr), 128'(16'h0040));
    check("t2_late_data", 128'(ram_wdata), 128'(W1));
    step();
    check("t2_addr_back", 128'(ram_addr), 128'(16'h0200));
    check("t2_ready_again", 128'(wr_ready), 128'(1));
    send_word(W2);
    check("t2_w1_addr", 128'(ram_addr), 128'(16'h0041));
    check("t2_done", 128'(done), 128'(1));
    step();
    check("t2_mem41", 128'(mem[16'h0041]), 128'(W2));
    check("t2_we_count", 128'(we_cnt - w0), 128'(2));

    // Zero-count and out-of-range loads
    w0 = we_cnt;
    start_load(16'h0050, 16'd0);
    check("t3_zero_done", 128'(done), 128'(1));
    check("t3_zero_busy", 128'(busy), 128'(0));
    check("t3_zero_ready", 128'(wr_ready), 128'(0));
    step();
    check("t3_zero_done_pulse", 128'(done), 128'(0));
    start_load(16'hFFFF, 16'd2);
    check("t3_range_err", 128'(err), 128'(1));
    check("t3_range_busy", 128'(busy), 128'(0));
    check("t3_range_ready", 128'(wr_ready), 128'(0));
    step();
    check("t3_range_err_pulse", 128'(err), 128'(0));
    check("t3_range_busy2", 128'(busy), 128'(0));
    check("t3_no_writes", 128'(we_cnt - w0), 128'(0));
    start_load(16'hFFFF, 16'd1);
    check("t3_top_ready", 128'(wr_ready), 128'(1));
    send_word(W3);
    check("t3_top_addr", 128'(ram_addr), 128'(16'hFFFF));
    check("t3_top_done", 128'(done), 128'(1));
    step();
    check("t3_top_mem", 128'(mem[16'hFFFF]), 128'(W3));

    // Abort mid word 1 of a three-word load, with a colliding load_start
    w0 = we_cnt; e0 = err_cnt;
    start_load(16'h0080, 16'd3);
    send_word(W1);
    step();
    send_beat(beat_of(W2, 0));
    send_beat(beat_of(W2, 1));
    send_beat(beat_of(W2, 2));
    abort = 1'b1;
    load_start = 1'b1;
    load_base = 16'h0000;
    load_count = 16'd1;
    step();
    abort = 1'b0;
    load_start = 1'b0;
    check("t4_abort_err", 128'(err), 128'(1));
    check("t4_abort_busy", 128'(busy), 128'(0));
    check("t4_abort_ready", 128'(wr_ready), 128'(0));
    step();
    check("t4_start_ignored", 128'(wr_ready), 128'(0));
    check("t4_err_pulse", 128'(err), 128'(0));
    repeat (4) step();
    check("t4_mem80", 128'(mem[16'h0080]), 128'(W1));
    check("t4_mem81_untouched", 128'(mem.exists(16'h0081)), 128'(0));
    check("t4_mem00_untouched", 128'(mem.exists(16'h0000)), 128'(0));
    check("t4_we_count", 128'(we_cnt - w0), 128'(1));
    check("t4_err_count", 128'(err_cnt - e0), 128'(1));

    // load_start while busy is rejected without disturbing the load
    w0 = we_cnt; d0 = done_cnt;
    start_load(16'h00A0, 16'd2);
    send_beat(beat_of(W3, 0));
    load_base = 16'h0030;
    load_count = 16'd5;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("t5_busy_err", 128'(err), 128'(1));
    check("t5_still_busy", 128'(busy), 128'(1));
    check("t5_still_ready", 128'(wr_ready), 128'(1));
    send_beat(beat_of(W3, 1));
    send_beat(beat_of(W3, 2));
    send_beat(beat_of(W3, 3));
    check("t5_w0_addr", 128'(ram_addr), 128'(16'h00A0));
    check("t5_w0_data", 128'(ram_wdata), 128'(W3));
    step();
    send_word(W2);
    check("t5_w1_addr", 128'(ram_addr), 128'(16'h00A1));
    check("t5_done", 128'(done), 128'(1));
    step();
    check("t5_memA1", 128'(mem[16'h00A1]), 128'(W2));
    check("t5_mem30_untouched", 128'(mem.exists(16'h0030)), 128'(0));
    check("t5_we_count", 128'(we_cnt - w0), 128'(2));
    check("t5_done_count", 128'(done_cnt - d0), 128'(1));

    // Reset during a write stall, then a fresh load
    start_load(16'h00C0, 16'd1);
    dec_run = 1'b1;
    dec_addr = 16'h0777;
    send_word(W2);
    repeat (3) step();
    check("t6_stalled", 128'(ram_we), 128'(0));
    reset = 1'b0;
    #1;
    check("t6_rst_ready", 128'(wr_ready), 128'(0));
    check("t6_rst_we", 128'(ram_we), 128'(0));
    check("t6_rst_wdata", 128'(ram_wdata), 128'(0));
    check("t6_rst_busy", 128'(busy), 128'(0));
    check("t6_rst_done", 128'(done), 128'(0));
    check("t6_rst_err", 128'(err), 128'(0));
    check("t6_rst_addr", 128'(ram_addr), 128'(16'h0777));
    step();
    reset = 1'b1;
    dec_run = 1'b0;
    step();
    check("t6_no_stale_write", 128'(mem.exists(16'h00C0)), 128'(0));
    start_load(16'h00C0, 16'd1);
    check("t6_fresh_ready", 128'(wr_ready), 128'(1));
    send_word(W3);
    check("t6_fresh_we", 128'(ram_we), 128'(1));
    check("t6_fresh_addr", 128'(ram_addr), 128'(16'h00C0));
    check("t6_fresh_done", 128'(done), 128'(1));
    step();
    check("t6_fresh_mem", 128'(mem[16'h00C0]), 128'(W3));
    check("t6_fresh_idle", 128'(busy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_loader.md
# seq_loader

Host-to-instruction-memory loader and port arbiter for the pulse sequencer. It assembles 32-bit host beats into 120-bit instruction words ({flg[63:0], op_code[3:0], data[19:0], time_arg[31:0]}) and writes them into the single-port instruction RAM. It shares that RAM with the decoder's fetch port and gives the decoder absolute priority while a sequence runs. It sits between the host register/stream interface, the decoder and the instruction RAM.

## Interface
Parameters:
- ADDR_SIZE, 16, instruction RAM address width (matches decoder)
- WORD_W, 120, instruction word width; fixed by the field layout

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse; begins a load
- load_base  in  ADDR_SIZE  first RAM address; sampled on load_start
- load_count  in  ADDR_SIZE  number of words to load; sampled on load_start
- abort  in  1  one-cycle pulse; cancels the load in progress
- wr_valid  in  1  host beat valid
- wr_data  in  32  host beat
- wr_ready  out  1  beat accepted when wr_valid & wr_ready
- dec_run  in  1  decoder running; decoder owns the RAM while high
- dec_addr  in  ADDR_SIZE  decoder fetch address (decoder mem_addr)
- ram_addr  out  ADDR_SIZE  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  WORD_W  RAM write data
- busy  out  1  load in progress
- done  out  1  one-cycle pulse; load completed
- err  out  1  one-cycle pulse; load rejected or aborted

## Operation
- FSM states: IDLE, COLLECT, WRITE.
- IDLE: wr_ready=0, busy=0. On load_start:
  - load_count==0: pulse done; stay in IDLE.
  - load_base+load_count > 2^ADDR_SIZE (evaluated at ADDR_SIZE+1 bits): pulse err; stay in IDLE.
  - Otherwise latch base and count, clear beat_cnt and word_idx, go to COLLECT.
- COLLECT: wr_ready=1, busy=1. Each accepted beat is stored by beat_cnt (0..3):
  - beat0 -> word[119:88]
  - beat1 -> word[87:56]
  - beat2 -> word[55:24]
  - beat3 -> word[23:0] from wr_data[23:0]; wr_data[31:24] is ignored.
  - When beat 3 is accepted, go to WRITE.
- WRITE: wr_ready=0.
  - dec_run=1: stall with ram_we=0.
  - dec_run=0: assert ram_we for exactly one cycle, with ram_addr=base+word_idx and ram_wdata=assembled word. Then increment word_idx.
  - If word_idx+1==count, pulse done and go to IDLE; otherwise return to COLLECT.
- Address mux: ram_addr=dec_addr in every cycle except the single write cycle. Since that cycle requires dec_run=0, decoder fetches are never disturbed while running.
- abort (any state except IDLE): go to IDLE next cycle; the partial word is discarded with no write; pulse err. Words already written stay in RAM.
- load_start while busy: ignored; pulse err; the load in progress continues unaffected.
- abort and load_start in the same cycle: abort wins; load_start is ignored.
- dec_run rising while in COLLECT: beats are still accepted; the stall applies only in WRITE.

## Timing
- Reset values: wr_ready=0, ram_we=0, ram_wdata=0, busy=0, done=0, err=0, FSM=IDLE. ram_addr follows dec_addr combinationally, including during reset.
- load_start at cycle N -> wr_ready=1 at N+1.
- Beat 3 accepted at cycle M with dec_run=0 -> ram_we=1 at M+1 -> wr_ready=1 at M+2, or done=1 at M+1 for the last word.
- Peak throughput: 1 word per 5 cycles.
- done and err are registered one-cycle pulses; busy deasserts in the cycle after done.
- All state is registered; the only combinational paths are ram_addr (dec_addr passthrough) and wr_ready (decoded from state).

## Structure
- Package seq_pkg:
  - Field widths: FLG_W=64, OP_W=4, DATA_W=20, TIME_W=32, WORD_W=120.
  - Beat bit-slice constants.
  - Load-FSM state enum.
  - Packed instruction struct, shared with the decoder.
- Sub-module seq_beat_packer: beat_cnt plus the 120-bit assembly register. Inputs: accept, clear, data. Outputs: word, word_valid.
- The FSM, arbitration mux and address counter live in seq_loader.

## Test plan
- Load base=0x0010, count=2, eight beats with dec_run=0 -> two ram_we pulses at 0x0010 and 0x0011; RAM holds {64'b1, 4'd2, 20'd20, 32'd0} and {64'b0, 4'd3, 20'd2, 32'd0}; one done pulse.
- Same load with dec_run=1 from beat 2 until 30 cycles later -> ram_we stays 0 during the stall; ram_addr tracks dec_addr; write lands the cycle after dec_run falls.
- load_count=0 -> done pulse the next cycle, no writes. base=0xFFFF, count=2 -> err pulse, no writes, busy stays 0.
- abort after beat 2 of word 1 of a 3-word load -> err pulse, IDLE next cycle, word 0 in RAM, word 1 address untouched.
- load_start while busy -> err pulse; the original load completes with the correct count and done.
- Assert reset mid-WRITE stall -> all outputs at reset values immediately; after release, a fresh load works normally.
